// File: rtl/hazwell_mem_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM state encoding,
// requester IDs and the memory read/write polarity.
package hazwell_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic REQ_FETCH    = 1'b0;
    localparam logic REQ_DATA     = 1'b1;

    localparam logic MEM_RW_READ  = 1'b0;
    localparam logic MEM_RW_WRITE = 1'b1;

    // Wide enough for the largest legal latency of 15 cycles.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant select between instruction fetch and load/store.
// MEM_ARBITER_RR_EN selects round-robin; otherwise data has fixed priority.
module mem_arb_pick
    import hazwell_mem_pkg::*;
(
    input  logic fetchReq_i,
    input  logic dataReq_i,
    input  logic lastGrant_i,
    output logic anyReq_o,
    output logic winner_o
);

    assign anyReq_o = fetchReq_i | dataReq_i;

`ifdef MEM_ARBITER_RR_EN
    // On contention the requester that was not granted last time wins.
    always_comb begin
        winner_o = REQ_DATA;
        if (fetchReq_i && dataReq_i) begin
            winner_o = (lastGrant_i == REQ_DATA) ? REQ_FETCH : REQ_DATA;
        end else if (fetchReq_i) begin
            winner_o = REQ_FETCH;
        end
    end
`else
    logic unusedLastGrant;
    assign unusedLastGrant = lastGrant_i;

    always_comb begin
        winner_o = dataReq_i ? REQ_DATA : REQ_FETCH;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store, one word per access
// with a fixed MEM_LAT-cycle latency. MEM_ARBITER_RR_EN enables round-robin.
module mem_arbiter
    import hazwell_mem_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iFetchReq,
    input  logic [31:0] iFetchAddr,
    output logic [31:0] oFetchData,
    output logic        oFetchAck,
    input  logic        iDataReq,
    input  logic        iDataRW,
    input  logic [31:0] iDataAddr,
    input  logic [31:0] iDataWr,
    output logic [31:0] oDataRd,
    output logic        oDataAck,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemData,
    input  logic [31:0] iMemData,
    output logic        oMemRW,
    output logic        oMemEn
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic              winner_q, winner_d;
    logic              memEn_q, memEn_d;
    logic              fetchAck_q, fetchAck_d;
    logic              dataAck_q, dataAck_d;
    logic [31:0]       fetchData_q, fetchData_d;
    logic [31:0]       dataRd_q, dataRd_d;
    logic              lastGrant;
    logic              anyReq;
    logic              pick;

`ifdef MEM_ARBITER_RR_EN
    logic lastGrant_q, lastGrant_d;
    assign lastGrant = lastGrant_q;
`else
    assign lastGrant = REQ_FETCH;
`endif

    mem_arb_pick u_pick (
        .fetchReq_i  (iFetchReq),
        .dataReq_i   (iDataReq),
        .lastGrant_i (lastGrant),
        .anyReq_o    (anyReq),
        .winner_o    (pick)
    );

    // Next-state and registered-output logic; everything holds unless a
    // transition below says otherwise, and the ack pulses self-clear.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        winner_d    = winner_q;
        memEn_d     = 1'b0;
        fetchAck_d  = 1'b0;
        dataAck_d   = 1'b0;
        fetchData_d = fetchData_q;
        dataRd_d    = dataRd_q;
`ifdef MEM_ARBITER_RR_EN
        lastGrant_d = lastGrant_q;
`endif

        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    state_d  = ACCESS;
                    cnt_d    = LAT_LOAD;
                    winner_d = pick;
                    memEn_d  = 1'b1;
`ifdef MEM_ARBITER_RR_EN
                    lastGrant_d = pick;
`endif
                    if (pick == REQ_DATA) begin
                        addr_d  = iDataAddr;
                        wdata_d = iDataWr;
                        rw_d    = iDataRW;
                    end else begin
                        addr_d  = iFetchAddr;
                        rw_d    = MEM_RW_READ;
                    end
                end
            end

            ACCESS: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    if (winner_q == REQ_DATA) begin
                        dataAck_d = 1'b1;
                        if (rw_q != MEM_RW_WRITE) begin
                            dataRd_d = iMemData;
                        end
                    end else begin
                        fetchAck_d  = 1'b1;
                        fetchData_d = iMemData;
                    end
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    memEn_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Synchronous reset drops any transaction in flight without an ack.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rw_q        <= MEM_RW_READ;
            winner_q    <= REQ_FETCH;
            memEn_q     <= 1'b0;
            fetchAck_q  <= 1'b0;
            dataAck_q   <= 1'b0;
            fetchData_q <= '0;
            dataRd_q    <= '0;
`ifdef MEM_ARBITER_RR_EN
            lastGrant_q <= REQ_FETCH;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rw_q        <= rw_d;
            winner_q    <= winner_d;
            memEn_q     <= memEn_d;
            fetchAck_q  <= fetchAck_d;
            dataAck_q   <= dataAck_d;
            fetchData_q <= fetchData_d;
            dataRd_q    <= dataRd_d;
`ifdef MEM_ARBITER_RR_EN
            lastGrant_q <= lastGrant_d;
`endif
        end
    end

    assign oMemEn     = memEn_q;
    assign oMemRW     = rw_q;
    assign oMemAddr   = addr_q;
    assign oMemData   = wdata_q;
    assign oFetchAck  = fetchAck_q;
    assign oFetchData = fetchData_q;
    assign oDataAck   = dataAck_q;
    assign oDataRd    = dataRd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at MEM_LAT=3 with a small combinational
// memory model; grant-order expectations follow MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetchReq;
    logic [31:0] fetchAddr;
    logic [31:0] fetchData;
    logic        fetchAck;
    logic        dataReq;
    logic        dataRW;
    logic [31:0] dataAddr;
    logic [31:0] dataWr;
    logic [31:0] dataRd;
    logic        dataAck;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memRW;
    logic        memEn;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(LAT)) dut (
        .iClk       (clk),
        .iRst       (rst),
        .iFetchReq  (fetchReq),
        .iFetchAddr (fetchAddr),
        .oFetchData (fetchData),
        .oFetchAck  (fetchAck),
        .iDataReq   (dataReq),
        .iDataRW    (dataRW),
        .iDataAddr  (dataAddr),
        .iDataWr    (dataWr),
        .oDataRd    (dataRd),
        .oDataAck   (dataAck),
        .oMemAddr   (memAddr),
        .oMemData   (memWData),
        .iMemData   (memRData),
        .oMemRW     (memRW),
        .oMemEn     (memEn)
    );

    function automatic logic [31:0] memModel(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0080_0857;
            32'h0000_0004: return 32'h1111_1111;
            32'h0000_0008: return 32'h2222_2222;
            32'h0000_0010: return 32'h3333_3333;
            default:       return 32'hBAD0_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    assign memRData = memModel(memAddr);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_memEn"},     memEn,     32'd0);
        checkOutput({tag, "_memRW"},     memRW,     32'd0);
        checkOutput({tag, "_memAddr"},   memAddr,   32'd0);
        checkOutput({tag, "_memData"},   memWData,  32'd0);
        checkOutput({tag, "_fetchAck"},  fetchAck,  32'd0);
        checkOutput({tag, "_dataAck"},   dataAck,   32'd0);
        checkOutput({tag, "_fetchData"}, fetchData, 32'd0);
        checkOutput({tag, "_dataRd"},    dataRd,    32'd0);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] expGrant [4];
        int         grants;
        int         lastAck;
        int         ackSeen;

`ifdef MEM_ARBITER_RR_EN
        expGrant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        expGrant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

        rst       = 1'b1;
        fetchReq  = 1'b0;
        fetchAddr = '0;
        dataReq   = 1'b0;
        dataRW    = 1'b0;
        dataAddr  = '0;
        dataWr    = '0;
        repeat (3) @(negedge clk);
        checkResetValues("init");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single fetch from 0x0");
        fetchReq  = 1'b1;
        fetchAddr = 32'h0;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            checkOutput($sformatf("fetch_en%0d", c), memEn, 32'd1);
            checkOutput($sformatf("fetch_noack%0d", c), fetchAck, 32'd0);
        end
        checkOutput("fetch_rw", memRW, 32'd0);
        @(negedge clk);
        checkOutput("fetch_ack", fetchAck, 32'd1);
        checkOutput("fetch_data", fetchData, 32'h0080_0857);
        checkOutput("fetch_en_off", memEn, 32'd0);
        checkOutput("fetch_dataAck", dataAck, 32'd0);
        fetchReq = 1'b0;
        @(negedge clk);
        checkOutput("fetch_ack_pulse", fetchAck, 32'd0);

        $display("[TB] simultaneous fetch 0x4 and data read 0x8");
        fetchReq  = 1'b1;
        fetchAddr = 32'h4;
        dataReq   = 1'b1;
        dataRW    = 1'b0;
        dataAddr  = 32'h8;
        @(negedge clk);
        checkOutput("cont_first_addr", memAddr, 32'h8);
        repeat (LAT - 1) @(negedge clk);
        @(negedge clk);
        checkOutput("cont_dataAck", dataAck, 32'd1);
        checkOutput("cont_dataRd", dataRd, 32'h2222_2222);
        checkOutput("cont_fetch_wait", fetchAck, 32'd0);
        dataReq = 1'b0;
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            checkOutput($sformatf("cont_fetch_noack%0d", c), fetchAck, 32'd0);
            if (c == 1) checkOutput("cont_gap_en", memEn, 32'd0);
            if (c == 2) checkOutput("cont_second_addr", memAddr, 32'h4);
        end
        @(negedge clk);
        checkOutput("cont_fetchAck", fetchAck, 32'd1);
        checkOutput("cont_fetchData", fetchData, 32'h1111_1111);
        fetchReq = 1'b0;
        @(negedge clk);

        $display("[TB] both requests held for four transactions");
        fetchReq  = 1'b1;
        fetchAddr = 32'h4;
        dataReq   = 1'b1;
        dataRW    = 1'b0;
        dataAddr  = 32'h10;
        grants    = 0;
        lastAck   = 0;
        for (int c = 0; c < 60 && grants < 4; c++) begin
            @(negedge clk);
            if (fetchAck || dataAck) begin
                checkOutput($sformatf("grant%0d", grants), {30'd0, fetchAck, dataAck},
                            {30'd0, expGrant[grants]});
                if (grants > 0) checkOutput($sformatf("spacing%0d", grants), c - lastAck, LAT + 2);
                lastAck = c;
                grants++;
            end
        end
        fetchReq = 1'b0;
        dataReq  = 1'b0;
        checkOutput("grant_count", grants, 32'd4);
        checkOutput("grant_dataRd", dataRd, 32'h3333_3333);
        @(negedge clk);

        $display("[TB] data write with operands changing mid-access");
        dataReq  = 1'b1;
        dataRW   = 1'b1;
        dataAddr = 32'h100;
        dataWr   = 32'hDEAD_BEEF;
        @(negedge clk);
        checkOutput("wr_en", memEn, 32'd1);
        dataAddr = 32'h200;
        dataWr   = 32'h0;
        for (int c = 1; c <= LAT; c++) begin
            if (c > 1) @(negedge clk);
            checkOutput($sformatf("wr_rw%0d", c), memRW, 32'd1);
            checkOutput($sformatf("wr_addr%0d", c), memAddr, 32'h100);
            checkOutput($sformatf("wr_data%0d", c), memWData, 32'hDEAD_BEEF);
        end
        @(negedge clk);
        checkOutput("wr_ack", dataAck, 32'd1);
        checkOutput("wr_rd_kept", dataRd, 32'h3333_3333);
        checkOutput("wr_en_off", memEn, 32'd0);
        dataReq = 1'b0;
        dataRW  = 1'b0;
        @(negedge clk);
        checkOutput("wr_addr_held", memAddr, 32'h100);

        $display("[TB] reset during access");
        dataReq  = 1'b1;
        dataAddr = 32'h10;
        repeat (2) @(negedge clk);
        checkOutput("rst_mid_en", memEn, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("rst_mid");
        rst     = 1'b0;
        dataReq = 1'b0;
        ackSeen = 0;
        repeat (8) begin
            @(negedge clk);
            if (fetchAck || dataAck || memEn) ackSeen++;
        end
        checkOutput("rst_no_ack", ackSeen, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
